// File: rtl/cpu_pkg.sv
// Shared CPU constants: ALU control codes, ALU_OP encodings, R-type funct
// values and default datapath widths. The ALU decodes the same ALUC values.
package cpu_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int RADDR_DEF = 5;

  localparam logic [3:0] ALUC_AND = 4'b0000;
  localparam logic [3:0] ALUC_OR  = 4'b0001;
  localparam logic [3:0] ALUC_ADD = 4'b0010;
  localparam logic [3:0] ALUC_SUB = 4'b0110;
  localparam logic [3:0] ALUC_BEQ = 4'b1000;
  localparam logic [3:0] ALUC_BNE = 4'b1100;

  typedef enum logic [1:0] {
    ALU_OP_ADD    = 2'b00,
    ALU_OP_BRANCH = 2'b01,
    ALU_OP_RTYPE  = 2'b10,
    ALU_OP_ORI    = 2'b11
  } alu_op_t;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;

endpackage

// File: rtl/alu_ctrl.sv
// ALU control decode: alu_op / funct / bne -> 4-bit ALUC plus an illegal flag
// for R-type instructions carrying a funct this ALU does not implement.
module alu_ctrl
  import cpu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  input  logic       bne,
  output logic [3:0] aluc,
  output logic       illegal
);

  // Unknown R-type funct falls back to ADD so the ALU still sees a defined code.
  always_comb begin
    aluc    = ALUC_ADD;
    illegal = 1'b0;
    case (alu_op_t'(alu_op))
      ALU_OP_ADD:    aluc = ALUC_ADD;
      ALU_OP_BRANCH: aluc = bne ? ALUC_BNE : ALUC_BEQ;
      ALU_OP_ORI:    aluc = ALUC_OR;
      ALU_OP_RTYPE: begin
        case (funct)
          FUNCT_ADD: aluc = ALUC_ADD;
          FUNCT_SUB: aluc = ALUC_SUB;
          FUNCT_AND: aluc = ALUC_AND;
          FUNCT_OR:  aluc = ALUC_OR;
          default: begin
            aluc    = ALUC_ADD;
            illegal = 1'b1;
          end
        endcase
      end
      default: aluc = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU. Captures decoded fields and
// register-file operands, resolves EX/MEM and MEM/WB forwarding on the
// registered source indices, and stalls ID/IF on a load-use hazard.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int RADDR = RADDR_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [1:0]       id_alu_op,
  input  logic [5:0]       id_funct,
  input  logic             id_bne,
  input  logic [RADDR-1:0] id_rs,
  input  logic [RADDR-1:0] id_rt,
  input  logic [RADDR-1:0] id_rd,
  input  logic [XLEN-1:0]  id_rs_data,
  input  logic [XLEN-1:0]  id_rt_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic             id_alusrc,
  input  logic             id_regdst,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             id_memtoreg,
  input  logic             hold,
  input  logic             flush,
  input  logic             mem_regwrite,
  input  logic [RADDR-1:0] mem_rd,
  input  logic [XLEN-1:0]  mem_alu_out,
  input  logic             wb_regwrite,
  input  logic [RADDR-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic [XLEN-1:0]  ALUIN1,
  output logic [XLEN-1:0]  ALUIN2,
  output logic [3:0]       ALUC,
  output logic [XLEN-1:0]  ex_store_data,
  output logic [RADDR-1:0] ex_dest,
  output logic             ex_valid,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_memtoreg,
  output logic             ex_illegal,
  output logic             stall_req
);

  logic [RADDR-1:0] rs_q, rt_q;
  logic [XLEN-1:0]  rs_data_q, rt_data_q, imm_q;
  logic             alusrc_q;
  logic [3:0]       aluc_dec;
  logic             illegal_dec;
  logic [XLEN-1:0]  fwd_rs, fwd_rt;
  logic             bubble;

  alu_ctrl u_alu_ctrl (
    .alu_op  (id_alu_op),
    .funct   (id_funct),
    .bne     (id_bne),
    .aluc    (aluc_dec),
    .illegal (illegal_dec)
  );

  // Load in EX whose result the ID instruction reads: hold ID/IF one cycle.
  assign stall_req = ex_valid && ex_memread && (ex_dest != '0) && id_valid &&
                     ((ex_dest == id_rs) || ((ex_dest == id_rt) && !id_alusrc));

  // Reset and flush override hold; a stall or an empty ID slot inserts a bubble.
  assign bubble = reset || flush || (!hold && (stall_req || !id_valid));

  // Pipeline register update: bubble, freeze, or capture.
  always_ff @(posedge clk) begin
    if (bubble) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_illegal  <= 1'b0;
      ALUC        <= ALUC_ADD;
      ex_dest     <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      alusrc_q    <= 1'b0;
    end else if (!hold) begin
      ex_valid    <= 1'b1;
      ex_regwrite <= id_regwrite;
      ex_memread  <= id_memread;
      ex_memwrite <= id_memwrite;
      ex_memtoreg <= id_memtoreg;
      ex_illegal  <= illegal_dec;
      ALUC        <= aluc_dec;
      ex_dest     <= id_regdst ? id_rd : id_rt;
      rs_q        <= id_rs;
      rt_q        <= id_rt;
      rs_data_q   <= id_rs_data;
      rt_data_q   <= id_rt_data;
      imm_q       <= id_imm;
      alusrc_q    <= id_alusrc;
    end
  end

  // Operand forwarding: youngest producer (EX/MEM) wins, register 0 never forwards.
  always_comb begin
    fwd_rs = rs_data_q;
    if (mem_regwrite && (mem_rd != '0) && (mem_rd == rs_q))
      fwd_rs = mem_alu_out;
    else if (wb_regwrite && (wb_rd != '0) && (wb_rd == rs_q))
      fwd_rs = wb_data;
  end

  // Same selection for the rt operand.
  always_comb begin
    fwd_rt = rt_data_q;
    if (mem_regwrite && (mem_rd != '0) && (mem_rd == rt_q))
      fwd_rt = mem_alu_out;
    else if (wb_regwrite && (wb_rd != '0) && (wb_rd == rt_q))
      fwd_rt = wb_data;
  end

  assign ALUIN1        = fwd_rs;
  assign ALUIN2        = alusrc_q ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, hand-written multi-cycle
// sequences, then randomized traffic against a behavioural reference model.
module tb_id_ex_stage;

  logic        clk;
  logic        reset, id_valid, id_bne;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_funct;
  logic [4:0]  id_rs, id_rt, id_rd, mem_rd, wb_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm, mem_alu_out, wb_data;
  logic        id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic        hold, flush, mem_regwrite, wb_regwrite;
  logic [31:0] ALUIN1, ALUIN2, ex_store_data;
  logic [3:0]  ALUC;
  logic [4:0]  ex_dest;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_illegal, stall_req;

  int total = 0;
  int bad   = 0;

  id_ex_stage #(.XLEN(32), .RADDR(5)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_alu_op(id_alu_op),
    .id_funct(id_funct), .id_bne(id_bne), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .hold(hold), .flush(flush), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
    .mem_alu_out(mem_alu_out), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .ALUIN1(ALUIN1), .ALUIN2(ALUIN2), .ALUC(ALUC), .ex_store_data(ex_store_data),
    .ex_dest(ex_dest), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
    .ex_illegal(ex_illegal), .stall_req(stall_req)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    reset = 0; id_valid = 0; id_alu_op = 0; id_funct = 0; id_bne = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_alusrc = 0; id_regdst = 0; id_regwrite = 0; id_memread = 0; id_memwrite = 0;
    id_memtoreg = 0; hold = 0; flush = 0; mem_regwrite = 0; mem_rd = 0;
    mem_alu_out = 0; wb_regwrite = 0; wb_rd = 0; wb_data = 0;
  endtask

  // ---------------- reference model ----------------
  // Model of what sits in EX: the instruction as described by ID when it was taken.
  logic        m_valid, m_regwrite, m_memread, m_memwrite, m_memtoreg, m_illegal, m_alusrc;
  logic [3:0]  m_aluc;
  logic [4:0]  m_dest, m_rs, m_rt;
  logic [31:0] m_rs_data, m_rt_data, m_imm;

  // Returns {illegal, aluc} from the ALU operation table.
  function automatic logic [4:0] ref_aluc(input logic [1:0] op, input logic [5:0] f, input logic b);
    if (op == 2'b00) return {1'b0, 4'b0010};
    if (op == 2'b01) return b ? {1'b0, 4'b1100} : {1'b0, 4'b1000};
    if (op == 2'b11) return {1'b0, 4'b0001};
    if (f == 6'b100000) return {1'b0, 4'b0010};
    if (f == 6'b100010) return {1'b0, 4'b0110};
    if (f == 6'b100100) return {1'b0, 4'b0000};
    if (f == 6'b100101) return {1'b0, 4'b0001};
    return {1'b1, 4'b0010};
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [4:0] r, input logic [31:0] d);
    if (r == 0) return d;
    if (mem_regwrite && mem_rd == r) return mem_alu_out;
    if (wb_regwrite && wb_rd == r) return wb_data;
    return d;
  endfunction

  function automatic logic ref_stall();
    if (!(m_valid && m_memread && m_dest != 0 && id_valid)) return 1'b0;
    return (m_dest == id_rs) || (m_dest == id_rt && !id_alusrc);
  endfunction

  task automatic m_bubble();
    m_valid = 0; m_regwrite = 0; m_memread = 0; m_memwrite = 0; m_memtoreg = 0;
    m_illegal = 0; m_aluc = 4'b0010; m_dest = 0; m_rs = 0; m_rt = 0;
    m_rs_data = 0; m_rt_data = 0; m_imm = 0; m_alusrc = 0;
  endtask

  task automatic model_edge();
    logic       st;
    logic [4:0] dec;
    st = ref_stall();
    if (reset || flush) m_bubble();
    else if (hold) begin end
    else if (st || !id_valid) m_bubble();
    else begin
      dec = ref_aluc(id_alu_op, id_funct, id_bne);
      m_valid = 1; m_regwrite = id_regwrite; m_memread = id_memread;
      m_memwrite = id_memwrite; m_memtoreg = id_memtoreg;
      m_illegal = dec[4]; m_aluc = dec[3:0];
      m_dest = id_regdst ? id_rd : id_rt;
      m_rs = id_rs; m_rt = id_rt; m_rs_data = id_rs_data; m_rt_data = id_rt_data;
      m_imm = id_imm; m_alusrc = id_alusrc;
    end
  endtask

  task automatic check_model();
    logic [31:0] e_rt;
    e_rt = ref_fwd(m_rt, m_rt_data);
    chk("rnd_aluin1", ALUIN1, ref_fwd(m_rs, m_rs_data));
    chk("rnd_aluin2", ALUIN2, m_alusrc ? m_imm : e_rt);
    chk("rnd_store", ex_store_data, e_rt);
    chk("rnd_aluc", {28'd0, ALUC}, {28'd0, m_aluc});
    chk("rnd_dest", {27'd0, ex_dest}, {27'd0, m_dest});
    chk("rnd_ctrl", {26'd0, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_illegal},
        {26'd0, m_valid, m_regwrite, m_memread, m_memwrite, m_memtoreg, m_illegal});
    chk("rnd_stall", {31'd0, stall_req}, {31'd0, ref_stall()});
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  op;
    logic [5:0]  funct;
    logic        bne, alusrc, regdst;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd, imm;
    logic [3:0]  e_aluc;
    logic        e_ill;
    logic [31:0] e_in1, e_in2;
    logic [4:0]  e_dest;
  } vec_t;

  vec_t vecs[11];

  initial begin
    set_idle();
    vecs[0]  = '{2'b10, 6'b100000, 0, 0, 1, 5'd1, 5'd2, 5'd3, 32'd5,  32'd7, 32'd0,    4'b0010, 0, 32'd5,  32'd7,    5'd3};
    vecs[1]  = '{2'b10, 6'b100010, 0, 0, 1, 5'd4, 5'd5, 5'd6, 32'd20, 32'd3, 32'd0,    4'b0110, 0, 32'd20, 32'd3,    5'd6};
    vecs[2]  = '{2'b10, 6'b100100, 0, 0, 1, 5'd7, 5'd8, 5'd9, 32'hF0, 32'h3C, 32'd0,   4'b0000, 0, 32'hF0, 32'h3C,   5'd9};
    vecs[3]  = '{2'b10, 6'b100101, 0, 0, 1, 5'd1, 5'd2, 5'd10, 32'h1, 32'h2, 32'd0,    4'b0001, 0, 32'h1,  32'h2,    5'd10};
    vecs[4]  = '{2'b10, 6'b101010, 0, 0, 1, 5'd1, 5'd2, 5'd11, 32'h8, 32'h9, 32'd0,    4'b0010, 1, 32'h8,  32'h9,    5'd11};
    vecs[5]  = '{2'b01, 6'b000000, 1, 0, 0, 5'd3, 5'd4, 5'd0, 32'h11, 32'h22, 32'd0,   4'b1100, 0, 32'h11, 32'h22,   5'd4};
    vecs[6]  = '{2'b01, 6'b000000, 0, 0, 0, 5'd3, 5'd4, 5'd0, 32'h11, 32'h11, 32'd0,   4'b1000, 0, 32'h11, 32'h11,   5'd4};
    vecs[7]  = '{2'b00, 6'b000000, 0, 1, 0, 5'd2, 5'd12, 5'd0, 32'h100, 32'h5, 32'h10, 4'b0010, 0, 32'h100, 32'h10,  5'd12};
    vecs[8]  = '{2'b11, 6'b000000, 0, 1, 0, 5'd2, 5'd13, 5'd0, 32'hA0, 32'h5, 32'hFF,  4'b0001, 0, 32'hA0, 32'hFF,   5'd13};
    vecs[9]  = '{2'b01, 6'b111111, 0, 0, 0, 5'd5, 5'd6, 5'd0, 32'h1, 32'h2, 32'd0,     4'b1000, 0, 32'h1,  32'h2,    5'd6};
    vecs[10] = '{2'b00, 6'b101010, 0, 1, 0, 5'd5, 5'd14, 5'd0, 32'h3, 32'h4, 32'hFFFFFFFC, 4'b0010, 0, 32'h3, 32'hFFFFFFFC, 5'd14};

    // Reset state
    reset = 1;
    tick();
    reset = 0;
    chk("rst_aluc", {28'd0, ALUC}, 32'h2);
    chk("rst_ctrl", {26'd0, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_illegal}, 32'h0);
    chk("rst_ops", ALUIN1 | ALUIN2 | ex_store_data, 32'h0);
    chk("rst_dest_stall", {26'd0, ex_dest, stall_req}, 32'h0);

    foreach (vecs[i]) begin
      set_idle();
      id_valid = 1; id_alu_op = vecs[i].op; id_funct = vecs[i].funct; id_bne = vecs[i].bne;
      id_alusrc = vecs[i].alusrc; id_regdst = vecs[i].regdst; id_regwrite = 1;
      id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_rd = vecs[i].rd;
      id_rs_data = vecs[i].rsd; id_rt_data = vecs[i].rtd; id_imm = vecs[i].imm;
      tick();
      chk($sformatf("vec%0d_aluc", i), {28'd0, ALUC}, {28'd0, vecs[i].e_aluc});
      chk($sformatf("vec%0d_ill", i), {31'd0, ex_illegal}, {31'd0, vecs[i].e_ill});
      chk($sformatf("vec%0d_in1", i), ALUIN1, vecs[i].e_in1);
      chk($sformatf("vec%0d_in2", i), ALUIN2, vecs[i].e_in2);
      chk($sformatf("vec%0d_dest", i), {27'd0, ex_dest}, {27'd0, vecs[i].e_dest});
      chk($sformatf("vec%0d_valid", i), {31'd0, ex_valid}, 32'd1);
    end

    // Forwarding priority
    set_idle();
    id_valid = 1; id_alu_op = 2'b10; id_funct = 6'b100000; id_regdst = 1; id_rd = 5'd9;
    id_rs = 5'd3; id_rt = 5'd6; id_rs_data = 32'h1; id_rt_data = 32'h2;
    tick();
    id_valid = 0;
    mem_regwrite = 1; mem_rd = 5'd3; mem_alu_out = 32'hA;
    wb_regwrite = 1; wb_rd = 5'd3; wb_data = 32'hB;
    #1 chk("fwd_mem_first", ALUIN1, 32'hA);
    chk("fwd_rt_untouched", ALUIN2, 32'h2);
    mem_regwrite = 0;
    #1 chk("fwd_wb", ALUIN1, 32'hB);
    wb_rd = 5'd6;
    #1 chk("fwd_wb_rt", ALUIN2, 32'hB);
    chk("fwd_wb_store", ex_store_data, 32'hB);
    chk("fwd_rs_back", ALUIN1, 32'h1);
    set_idle();
    id_valid = 1; id_alu_op = 2'b10; id_funct = 6'b100000; id_rs = 5'd0; id_rt = 5'd0;
    id_rs_data = 32'h55; id_rt_data = 32'h66;
    tick();
    mem_regwrite = 1; mem_rd = 0; mem_alu_out = 32'hA;
    wb_regwrite = 1; wb_rd = 0; wb_data = 32'hB;
    #1 chk("fwd_r0_rs", ALUIN1, 32'h55);
    chk("fwd_r0_rt", ex_store_data, 32'h66);

    // Load-use: one stall, one bubble, consumer captured next
    set_idle();
    id_valid = 1; id_alu_op = 2'b00; id_alusrc = 1; id_rs = 5'd1; id_rt = 5'd4;
    id_imm = 32'h8; id_regwrite = 1; id_memread = 1; id_memtoreg = 1;
    tick();
    set_idle();
    id_valid = 1; id_alu_op = 2'b10; id_funct = 6'b100010; id_regdst = 1;
    id_rs = 5'd4; id_rt = 5'd5; id_rd = 5'd7; id_rs_data = 32'h3; id_rt_data = 32'h1; id_regwrite = 1;
    #1 chk("lu_stall", {31'd0, stall_req}, 32'd1);
    tick();
    chk("lu_bubble", {29'd0, ex_valid, ex_memread, stall_req}, 32'd0);
    tick();
    chk("lu_consumer", {27'd0, ex_valid, ALUC}, {27'd0, 1'b1, 4'b0110});
    chk("lu_cons_dest", {27'd0, ex_dest}, 32'd7);
    wb_regwrite = 1; wb_rd = 5'd4; wb_data = 32'h77;
    #1 chk("lu_wb_fwd", ALUIN1, 32'h77);

    // Load followed by an immediate consumer of rt only: no hazard
    set_idle();
    id_valid = 1; id_alu_op = 2'b00; id_alusrc = 1; id_rt = 5'd4; id_memread = 1; id_regwrite = 1;
    tick();
    id_rs = 5'd2; id_rt = 5'd4; id_alusrc = 1; id_memread = 0;
    #1 chk("lu_imm_nostall", {31'd0, stall_req}, 32'd0);
    id_alusrc = 0;
    #1 chk("lu_rt_stall", {31'd0, stall_req}, 32'd1);

    // Hold freezes, flush beats hold
    set_idle();
    id_valid = 1; id_alu_op = 2'b10; id_funct = 6'b100010; id_rs = 5'd2; id_rt = 5'd3;
    id_rs_data = 32'h9; id_rt_data = 32'h4; id_regwrite = 1;
    tick();
    hold = 1; id_funct = 6'b100100; id_rs_data = 32'h99; id_rt_data = 32'h44;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("hold%0d_aluc", k), {28'd0, ALUC}, 32'h6);
      chk($sformatf("hold%0d_ops", k), {ALUIN1[15:0], ALUIN2[15:0]}, {16'h9, 16'h4});
      chk($sformatf("hold%0d_valid", k), {31'd0, ex_valid}, 32'd1);
    end
    flush = 1;
    tick();
    chk("flush_hold_ctrl", {27'd0, ex_valid, ALUC}, {27'd0, 1'b0, 4'b0010});
    chk("flush_hold_ops", ALUIN1 | ALUIN2, 32'h0);

    // Reset during a load-use stall
    set_idle();
    id_valid = 1; id_alu_op = 2'b00; id_alusrc = 1; id_rt = 5'd8; id_memread = 1; id_regwrite = 1;
    id_funct = 6'b101010;
    tick();
    id_alusrc = 0; id_rs = 5'd8; id_memread = 0;
    #1 chk("rst_mid_stall_pre", {31'd0, stall_req}, 32'd1);
    reset = 1;
    tick();
    reset = 0;
    chk("rst_mid_stall", {28'd0, stall_req, ex_valid, ex_memread, ex_regwrite}, 32'd0);
    chk("rst_mid_aluc", {28'd0, ALUC}, 32'h2);

    // Randomized traffic against the model
    set_idle();
    reset = 1;
    tick();
    m_bubble();
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 9) == 0);
      hold  = ($urandom_range(0, 6) == 0);
      id_valid = ($urandom_range(0, 5) != 0);
      id_alu_op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0: id_funct = 6'b100000;
        1: id_funct = 6'b100010;
        2: id_funct = 6'b100100;
        3: id_funct = 6'b100101;
        default: id_funct = 6'($urandom);
      endcase
      id_bne = 1'($urandom);
      id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7)); id_rd = 5'($urandom_range(0, 7));
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
      id_alusrc = 1'($urandom); id_regdst = 1'($urandom); id_regwrite = 1'($urandom);
      id_memread = ($urandom_range(0, 2) == 0); id_memwrite = 1'($urandom); id_memtoreg = 1'($urandom);
      mem_regwrite = 1'($urandom); mem_rd = 5'($urandom_range(0, 7)); mem_alu_out = $urandom;
      wb_regwrite = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
      #1 check_model();
      model_edge();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
